zone_gray_buffer: RTL and testbench



---
 rtl/zone_pkg.sv | 22 ++
 rtl/zone_bank_ram.sv | 34 +++
 rtl/zone_gray_buffer.sv | 242 ++++++++++++++++++++++++
 tb/tb_zone_gray_buffer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/zone_pkg.sv
// Shared types and sizing helpers for the zone gray buffer.
package zone_pkg;

    typedef enum logic {
        MODE_MAX  = 1'b0,
        MODE_MEAN = 1'b1
    } mode_e;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_e;

    function automatic int calc_nzones(input int zones_x, input int zones_y);
        return zones_x * zones_y;
    endfunction

    function automatic int calc_acc_w(input int dw, input int w_log2, input int h_log2);
        return dw + w_log2 + h_log2;
    endfunction

endpackage

// File: rtl/zone_bank_ram.sv
// Two-bank simple dual-port zone memory: one write port, one registered read port.
module zone_bank_ram #(
    parameter int DW = 8,
    parameter int AW = 9
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic          wr_bank_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_en_i,
    input  logic          rd_bank_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [DW-1:0] rd_data_o
);

    localparam int DEPTH = 2 ** (AW + 1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rd_data_q;

    // No reset on the array or read register so the tools can map this to block RAM.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[{wr_bank_i, wr_addr_i}] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[{rd_bank_i, rd_addr_i}];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/zone_gray_buffer.sv
// Reduces each video frame to a grid of per-zone gray levels (max or mean),
// double-buffered so the reader always sees a complete frame.
module zone_gray_buffer
    import zone_pkg::*;
#(
    parameter int DW          = 8,
    parameter int ZONES_X     = 24,
    parameter int ZONES_Y     = 15,
    parameter int ZONE_W_LOG2 = 5,
    parameter int ZONE_H_LOG2 = 5,
    parameter int AW          = 9
) (
    input  logic          I_clk,
    input  logic          I_rst_n,
    input  logic          I_vs,
    input  logic          I_hs,
    input  logic          I_de,
    input  logic [DW-1:0] I_data_r,
    input  logic [DW-1:0] I_data_g,
    input  logic [DW-1:0] I_data_b,
    input  logic          I_mode,
    input  logic          I_rd_en,
    input  logic [AW-1:0] I_rd_addr,
    output logic [DW-1:0] O_rd_data,
    output logic          O_rd_valid,
    output logic          O_frame_done,
    output logic          O_frame_drop
);

    localparam int NZONES = calc_nzones(ZONES_X, ZONES_Y);
    localparam int ACC_W  = calc_acc_w(DW, ZONE_W_LOG2, ZONE_H_LOG2);
    localparam int SHIFT  = ZONE_W_LOG2 + ZONE_H_LOG2;
    localparam int CW     = 16;
    localparam int COLW   = (ZONES_X > 1) ? $clog2(ZONES_X) : 1;
    localparam int BW     = $clog2(ZONES_Y + 1);

    logic unused_hs;
    assign unused_hs = I_hs;

    // Stage 1: registered gray and aligned sync/enable/mode.
    logic [DW-1:0] gray_d, gray_q;
    logic          vs_q, vs_prev_q, de_q, de_prev_q, mode_s1_q;

    always_comb begin
        gray_d = I_data_r;
        if (I_data_g > gray_d) gray_d = I_data_g;
        if (I_data_b > gray_d) gray_d = I_data_b;
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            gray_q    <= '0;
            vs_q      <= 1'b0;
            vs_prev_q <= 1'b0;
            de_q      <= 1'b0;
            de_prev_q <= 1'b0;
            mode_s1_q <= 1'b0;
        end else begin
            gray_q    <= gray_d;
            vs_q      <= I_vs;
            vs_prev_q <= vs_q;
            de_q      <= I_de;
            de_prev_q <= de_q;
            mode_s1_q <= I_mode;
        end
    end

    logic          vs_rise, de_fall, pix_ok, band_end, acc_clr;
    logic [CW-1:0] x_q, y_q, col_full, row_full;
    state_e        state_q, state_d;
    mode_e         mode_q;

    assign vs_rise  = vs_q & ~vs_prev_q;
    assign de_fall  = de_prev_q & ~de_q;
    assign col_full = x_q >> ZONE_W_LOG2;
    assign row_full = y_q >> ZONE_H_LOG2;
    assign pix_ok   = de_q && (col_full < CW'(ZONES_X)) && (row_full < CW'(ZONES_Y));
    assign band_end = de_fall && (y_q[ZONE_H_LOG2-1:0] == '1) && (row_full < CW'(ZONES_Y));
    assign acc_clr  = band_end | vs_rise;

    // Coordinates saturate so overlong lines/frames never alias back into the grid.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            if (de_fall)                 x_q <= '0;
            else if (de_q && x_q != '1)  x_q <= x_q + 1'b1;
            if (vs_rise)                 y_q <= '0;
            else if (de_fall && y_q != '1) y_q <= y_q + 1'b1;
        end
    end

    logic [ACC_W-1:0] hold_w [ZONES_X];

    for (genvar gi = 0; gi < ZONES_X; gi++) begin : g_acc
        logic [ACC_W-1:0] acc_q, hold_q;

        always_ff @(posedge I_clk or negedge I_rst_n) begin
            if (!I_rst_n) begin
                acc_q  <= '0;
                hold_q <= '0;
            end else if (acc_clr) begin
                acc_q <= '0;
                if (band_end && state_q == IDLE) hold_q <= acc_q;
            end else if (pix_ok && col_full == CW'(gi)) begin
                if (mode_q == MODE_MEAN)             acc_q <= acc_q + ACC_W'(gray_q);
                else if (ACC_W'(gray_q) > acc_q)     acc_q <= ACC_W'(gray_q);
            end
        end

        assign hold_w[gi] = hold_q;
    end

    // Flush FSM: one column per cycle from the holding registers into the write bank.
    logic [COLW-1:0] fcol_q, fcol_d;
    logic [AW-1:0]   band_row_q;
    logic            we, flush_last;
    logic [ACC_W-1:0] flush_val;
    logic [DW-1:0]   wr_data;
    logic [AW-1:0]   wr_addr;

    always_comb begin
        state_d    = state_q;
        fcol_d     = fcol_q;
        we         = 1'b0;
        flush_last = 1'b0;
        case (state_q)
            IDLE: begin
                if (band_end && !vs_rise) begin
                    state_d = FLUSH;
                    fcol_d  = '0;
                end
            end
            FLUSH: begin
                we     = 1'b1;
                fcol_d = fcol_q + 1'b1;
                if (fcol_q == COLW'(ZONES_X - 1)) begin
                    state_d    = IDLE;
                    flush_last = 1'b1;
                end
                if (vs_rise) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        flush_val = '0;
        for (int i = 0; i < ZONES_X; i++) begin
            if (fcol_q == COLW'(i)) flush_val = hold_w[i];
        end
    end

    assign wr_data = (mode_q == MODE_MEAN) ? DW'(flush_val >> SHIFT) : DW'(flush_val);
    assign wr_addr = AW'(band_row_q * AW'(ZONES_X) + AW'(fcol_q));

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q    <= IDLE;
            fcol_q     <= '0;
            band_row_q <= '0;
        end else begin
            state_q <= state_d;
            fcol_q  <= fcol_d;
            if (band_end && state_q == IDLE) band_row_q <= AW'(row_full);
        end
    end

    // Frame bookkeeping and bank swap.
    logic          rd_bank_q, incomplete_q, seen_q, done_q, drop_q;
    logic [1:0]    bank_valid_q;
    logic [BW-1:0] bands_done_q;

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            rd_bank_q    <= 1'b0;
            bank_valid_q <= '0;
            bands_done_q <= '0;
            incomplete_q <= 1'b0;
            seen_q       <= 1'b0;
            done_q       <= 1'b0;
            drop_q       <= 1'b0;
            mode_q       <= MODE_MAX;
        end else begin
            done_q <= 1'b0;
            drop_q <= 1'b0;
            if (vs_rise) begin
                if (bands_done_q == BW'(ZONES_Y) && state_q == IDLE && !incomplete_q) begin
                    rd_bank_q                <= ~rd_bank_q;
                    bank_valid_q[~rd_bank_q] <= 1'b1;
                    done_q                   <= 1'b1;
                end else if (seen_q) begin
                    drop_q <= 1'b1;
                end
                bands_done_q <= '0;
                incomplete_q <= 1'b0;
                seen_q       <= 1'b0;
                mode_q       <= mode_e'(mode_s1_q);
            end else begin
                if (band_end && state_q == FLUSH) incomplete_q <= 1'b1;
                if (flush_last)                   bands_done_q <= bands_done_q + 1'b1;
                if (de_q)                         seen_q       <= 1'b1;
            end
        end
    end

    // Read side: out-of-range or never-written bank is forced to zero after the RAM register.
    logic          zero_q, rd_valid_q;
    logic [DW-1:0] ram_rd_data;

    zone_bank_ram #(
        .DW (DW),
        .AW (AW)
    ) u_ram (
        .clk_i     (I_clk),
        .we_i      (we),
        .wr_bank_i (~rd_bank_q),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_en_i   (I_rd_en),
        .rd_bank_i (rd_bank_q),
        .rd_addr_i (I_rd_addr),
        .rd_data_o (ram_rd_data)
    );

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            zero_q     <= 1'b1;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= I_rd_en;
            if (I_rd_en) zero_q <= !((32'(I_rd_addr) < NZONES) && bank_valid_q[rd_bank_q]);
        end
    end

    assign O_rd_data    = zero_q ? '0 : ram_rd_data;
    assign O_rd_valid   = rd_valid_q;
    assign O_frame_done = done_q;
    assign O_frame_drop = drop_q;

endmodule

// File: tb/tb_zone_gray_buffer.sv
// Directed scoreboard bench for zone_gray_buffer on a 16x8 area split into 4x2 zones.
module tb_zone_gray_buffer;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          vs = 1'b0, hs = 1'b0, de = 1'b0, mode = 1'b0;
    logic [DW-1:0] r = '0, g = '0, b = '0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic          rd_valid, frame_done, frame_drop;

    always #5 clk = ~clk;

    zone_gray_buffer #(
        .DW(DW), .ZONES_X(4), .ZONES_Y(2), .ZONE_W_LOG2(2), .ZONE_H_LOG2(2), .AW(AW)
    ) dut (
        .I_clk(clk), .I_rst_n(rst_n), .I_vs(vs), .I_hs(hs), .I_de(de),
        .I_data_r(r), .I_data_g(g), .I_data_b(b), .I_mode(mode),
        .I_rd_en(rd_en), .I_rd_addr(rd_addr),
        .O_rd_data(rd_data), .O_rd_valid(rd_valid),
        .O_frame_done(frame_done), .O_frame_drop(frame_drop)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } rd_exp_t;

    rd_exp_t exp_q[$];
    int checks = 0;
    int fails  = 0;
    int done_cnt = 0, drop_cnt = 0;
    int exp_done = 0, exp_drop = 0;

    // Monitor: counts sync pulses and scores every read response against the queue.
    always @(negedge clk) begin
        rd_exp_t e;
        if (frame_done) done_cnt++;
        if (frame_drop) drop_cnt++;
        if (rd_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL rd_unexpected: valid with data %02h, no read pending", rd_data);
            end else begin
                e = exp_q.pop_front();
                if (rd_data !== e.data) begin
                    fails++;
                    $display("FAIL rd_data addr %0d: got %02h expected %02h", e.addr, rd_data, e.data);
                end else begin
                    $display("rd addr %0d data %02h ok", e.addr, rd_data);
                end
            end
        end
    end

    function automatic logic [23:0] pix(input int kind, input int x, input int y);
        logic [7:0] v;
        case (kind)
            0: return {8'h22, 8'h22, 8'h22};
            1: return (x == 5 && y == 1) ? {8'h10, 8'hF0, 8'h10} : {8'h10, 8'h10, 8'h10};
            2: begin
                v = 8'(y * 4 + x);
                if (x < 4 && y < 4) return {8'h00, v, 8'h00};
                return {8'h40, 8'h40, 8'h40};
            end
            default: return ((x % 4 == 0) && (y % 4 == 0)) ? {8'h80, 8'h00, 8'h00} : 24'h0;
        endcase
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end else begin
            $display("check %s = %0d ok", name, actual);
        end
    endtask

    task automatic vs_pulse(input logic mode_next);
        @(negedge clk);
        mode = mode_next;
        vs = 1'b1;
        repeat (2) @(negedge clk);
        vs = 1'b0;
        repeat (4) @(negedge clk);
        check("frame_done count", done_cnt, exp_done);
        check("frame_drop count", drop_cnt, exp_drop);
    endtask

    task automatic drive_lines(input int kind, input int nlines, input bit toggle_mode,
                               input bit rst_in_flush);
        logic [23:0] p;
        for (int y = 0; y < nlines; y++) begin
            for (int x = 0; x < 16; x++) begin
                @(negedge clk);
                p = pix(kind, x, y);
                de = 1'b1;
                {r, g, b} = p;
            end
            @(negedge clk);
            de = 1'b0;
            {r, g, b} = 24'h0;
            if (toggle_mode && y == 3) mode = ~mode;
            if (rst_in_flush && y == nlines - 1) begin
                repeat (2) @(negedge clk);
                rst_n = 1'b0;
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
            end
            repeat (5) @(negedge clk);
        end
        repeat (12) @(negedge clk);
    endtask

    task automatic rd_burst(input int first, input int last, input int kind_sel);
        rd_exp_t e;
        for (int a = first; a <= last; a++) begin
            @(negedge clk);
            rd_en = 1'b1;
            rd_addr = AW'(a);
            e.addr = AW'(a);
            case (kind_sel)
                1: e.data = (a == 1) ? 8'hF0 : 8'h10;
                2: e.data = (a == 0) ? 8'd7 : 8'h40;
                3: e.data = 8'h80;
                4: e.data = 8'd8;
                5: e.data = 8'h22;
                default: e.data = 8'h00;
            endcase
            if (a >= 8) e.data = 8'h00;
            exp_q.push_back(e);
        end
        @(negedge clk);
        rd_en = 1'b0;
        repeat (2) @(negedge clk);
        check("rd responses outstanding", exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset frame_done", int'(frame_done), 0);
        check("reset frame_drop", int'(frame_drop), 0);
        check("reset rd_valid", int'(rd_valid), 0);
        check("reset rd_data", int'(rd_data), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: nothing written yet, whole address space reads 0.
        rd_burst(0, 15, 0);

        // 2: max mode with a single bright green pixel in zone 1.
        vs_pulse(1'b0);
        drive_lines(1, 8, 1'b0, 1'b0);
        exp_done++;
        vs_pulse(1'b1);
        rd_burst(0, 15, 1);

        // 3: mean mode, ramp in zone 0.
        drive_lines(2, 8, 1'b0, 1'b0);
        exp_done++;
        vs_pulse(1'b1);
        rd_burst(0, 7, 2);

        // 4: truncated frame is dropped, previous frame stays readable.
        drive_lines(2, 6, 1'b0, 1'b0);
        exp_drop++;
        vs_pulse(1'b0);
        rd_burst(0, 7, 2);

        // 5: mode flipped mid-frame does not affect the frame in flight.
        drive_lines(3, 8, 1'b1, 1'b0);
        exp_done++;
        vs_pulse(1'b1);
        rd_burst(0, 7, 3);
        drive_lines(3, 8, 1'b1, 1'b0);
        exp_done++;
        vs_pulse(1'b0);
        rd_burst(0, 7, 4);

        // 6: reset during flush of band 1, then a clean frame.
        drive_lines(0, 8, 1'b0, 1'b1);
        rd_burst(0, 7, 0);
        vs_pulse(1'b0);
        drive_lines(0, 8, 1'b0, 1'b0);
        exp_done++;
        vs_pulse(1'b0);
        rd_burst(0, 7, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
